// File: rtl/text_edit_ctrl.sv
// Write-side controller for the text-mode character RAM.
// Turns keystrokes into RAM writes, keeps the cursor on a COLS x ROWS grid,
// and runs the whole-screen and single-row blanking sweeps.
module text_edit_ctrl #(
    parameter int         COLS  = 70,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  asciicode_in,
    input  logic        clear_req,
    output logic        ready,
    output logic        en,
    output logic [11:0] waddr,
    output logic [7:0]  asciicode,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic [11:0] cursor_addr
);

    localparam logic [11:0] CellCount = 12'(COLS * ROWS);
    localparam logic [11:0] RowLen    = 12'(COLS);
    localparam logic [6:0]  LastCol   = 7'(COLS - 1);
    localparam logic [4:0]  LastRow   = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        CLR_ROW
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] sweepCnt_q, sweepCnt_d;
    logic [4:0]  targetRow_q, targetRow_d;
    logic [4:0]  cursorRow_q, cursorRow_d;
    logic [6:0]  cursorCol_q, cursorCol_d;
    logic [11:0] cursorAddr_q, cursorAddr_d;
    logic        en_q, en_d;
    logic [11:0] waddr_q, waddr_d;
    logic [7:0]  ascii_q, ascii_d;

    logic inIdle;
    logic clearAccept;
    logic keyAccept;
    logic keyPrintable;
    logic keyBackspace;
    logic keyEnter;
    logic atLastCell;
    logic atLastRow;

    // A clear request always beats a simultaneous keystroke; the key is simply dropped
    assign inIdle       = (state_q == IDLE);
    assign clearAccept  = clear_req & inIdle;
    assign keyAccept    = key_valid & inIdle & ~clear_req;
    assign keyPrintable = (asciicode_in >= 8'h20) && (asciicode_in <= 8'h7E);
    assign keyBackspace = (asciicode_in == 8'h08);
    assign keyEnter     = (asciicode_in == 8'h0D);
    assign atLastRow    = (cursorRow_q == LastRow);
    assign atLastCell   = atLastRow && (cursorCol_q == LastCol);

    assign ready       = inIdle;
    assign en          = en_q;
    assign waddr       = waddr_q;
    assign asciicode   = ascii_q;
    assign cursor_row  = cursorRow_q;
    assign cursor_col  = cursorCol_q;
    assign cursor_addr = cursorAddr_q;

    // State and datapath registers; reset aborts any sweep and restarts the screen clear
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q      <= CLR_ALL;
            sweepCnt_q   <= '0;
            targetRow_q  <= '0;
            cursorRow_q  <= '0;
            cursorCol_q  <= '0;
            cursorAddr_q <= '0;
            en_q         <= 1'b0;
            waddr_q      <= '0;
            ascii_q      <= '0;
        end else begin
            state_q      <= state_d;
            sweepCnt_q   <= sweepCnt_d;
            targetRow_q  <= targetRow_d;
            cursorRow_q  <= cursorRow_d;
            cursorCol_q  <= cursorCol_d;
            cursorAddr_q <= cursorAddr_d;
            en_q         <= en_d;
            waddr_q      <= waddr_d;
            ascii_q      <= ascii_d;
        end
    end

    // Next state: sweeps end one cycle after their last write; wrapping off the bottom blanks row 0
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_ALL: begin
                if (sweepCnt_q == CellCount) begin
                    state_d = IDLE;
                end
            end
            CLR_ROW: begin
                if (sweepCnt_q == RowLen) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clearAccept) begin
                    state_d = CLR_ALL;
                end else if (keyAccept &&
                             ((keyPrintable && atLastCell) || (keyEnter && atLastRow))) begin
                    state_d = CLR_ROW;
                end
            end
            default: state_d = CLR_ALL;
        endcase
    end

    // Datapath: sweep writes, keystroke writes and cursor movement; write outputs hold when idle
    always_comb begin
        sweepCnt_d  = sweepCnt_q;
        targetRow_d = targetRow_q;
        cursorRow_d = cursorRow_q;
        cursorCol_d = cursorCol_q;
        en_d        = 1'b0;
        waddr_d     = waddr_q;
        ascii_d     = ascii_q;

        case (state_q)
            CLR_ALL: begin
                if (sweepCnt_q < CellCount) begin
                    en_d       = 1'b1;
                    waddr_d    = sweepCnt_q;
                    ascii_d    = BLANK;
                    sweepCnt_d = sweepCnt_q + 12'd1;
                end
            end
            CLR_ROW: begin
                if (sweepCnt_q < RowLen) begin
                    en_d       = 1'b1;
                    waddr_d    = (12'(targetRow_q) * RowLen) + sweepCnt_q;
                    ascii_d    = BLANK;
                    sweepCnt_d = sweepCnt_q + 12'd1;
                end
            end
            IDLE: begin
                if (clearAccept) begin
                    cursorRow_d = '0;
                    cursorCol_d = '0;
                    sweepCnt_d  = '0;
                end else if (keyAccept) begin
                    if (keyPrintable) begin
                        en_d    = 1'b1;
                        waddr_d = cursorAddr_q;
                        ascii_d = asciicode_in;
                        if (atLastCell) begin
                            cursorRow_d = '0;
                            cursorCol_d = '0;
                            sweepCnt_d  = '0;
                            targetRow_d = '0;
                        end else if (cursorCol_q != LastCol) begin
                            cursorCol_d = cursorCol_q + 7'd1;
                        end else begin
                            cursorCol_d = '0;
                            cursorRow_d = cursorRow_q + 5'd1;
                        end
                    end else if (keyBackspace) begin
                        // Stepping back one cell is always address-1, even across a row boundary
                        if (cursorCol_q != 7'd0) begin
                            cursorCol_d = cursorCol_q - 7'd1;
                            en_d        = 1'b1;
                            waddr_d     = cursorAddr_q - 12'd1;
                            ascii_d     = BLANK;
                        end else if (cursorRow_q != 5'd0) begin
                            cursorRow_d = cursorRow_q - 5'd1;
                            cursorCol_d = LastCol;
                            en_d        = 1'b1;
                            waddr_d     = cursorAddr_q - 12'd1;
                            ascii_d     = BLANK;
                        end
                    end else if (keyEnter) begin
                        if (atLastRow) begin
                            cursorRow_d = '0;
                            cursorCol_d = '0;
                            sweepCnt_d  = '0;
                            targetRow_d = '0;
                        end else begin
                            cursorRow_d = cursorRow_q + 5'd1;
                            cursorCol_d = '0;
                        end
                    end
                end
            end
            default: begin
                sweepCnt_d = '0;
            end
        endcase

        cursorAddr_d = (12'(cursorRow_d) * RowLen) + 12'(cursorCol_d);
    end

endmodule

// File: tb/tb_text_edit_ctrl.sv
// Randomized bench for text_edit_ctrl against a cell-level model of the editor.
module tb_text_edit_ctrl;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  asciicode_in = 8'h00;
    logic        clear_req = 1'b0;
    logic        ready;
    logic        en;
    logic [11:0] waddr;
    logic [7:0]  asciicode;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic [11:0] cursor_addr;

    typedef struct {
        logic        en;
        logic [11:0] addr;
        logic [7:0]  data;
        logic        rdy;
    } expEntry_t;

    expEntry_t   expQ[$];
    int          total = 0;
    int          bad = 0;
    int          mRow = 0;
    int          mCol = 0;
    logic [11:0] lastAddr = '0;
    logic [7:0]  lastData = '0;

    text_edit_ctrl #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .BLANK (8'h20)
    ) dut (
        .clk50        (clk50),
        .reset        (reset),
        .key_valid    (key_valid),
        .asciicode_in (asciicode_in),
        .clear_req    (clear_req),
        .ready        (ready),
        .en           (en),
        .waddr        (waddr),
        .asciicode    (asciicode),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .cursor_addr  (cursor_addr)
    );

    // 100 MHz-style free-running clock
    always #5 clk50 = ~clk50;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushWrite(input int addr, input logic [7:0] data, input logic rdy);
        expEntry_t e;
        e.en   = 1'b1;
        e.addr = 12'(addr);
        e.data = data;
        e.rdy  = rdy;
        expQ.push_back(e);
    endtask

    task automatic pushGap();
        expEntry_t e;
        e.en   = 1'b0;
        e.addr = '0;
        e.data = '0;
        e.rdy  = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic pushSweep(input int count);
        for (int k = 0; k < count; k++) begin
            pushWrite(k, 8'h20, 1'b0);
        end
    endtask

    task automatic driveIdle();
        key_valid    = 1'b0;
        clear_req    = 1'b0;
        asciicode_in = 8'h00;
    endtask

    task automatic driveJunk();
        key_valid    = 1'($urandom_range(0, 1));
        asciicode_in = 8'($urandom);
        clear_req    = ($urandom_range(0, 3) == 0);
    endtask

    // One clock: compare the DUT against the next expected cycle (or plain idle)
    task automatic sampleCycle(output logic rdyExp, output logic [11:0] addrSeen);
        expEntry_t e;
        @(posedge clk50);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
        end else begin
            e.en   = 1'b0;
            e.addr = '0;
            e.data = '0;
            e.rdy  = 1'b1;
        end
        checkOutput("en", 32'(en), 32'(e.en));
        checkOutput("ready", 32'(ready), 32'(e.rdy));
        if (e.en) begin
            checkOutput("waddr", 32'(waddr), 32'(e.addr));
            checkOutput("asciicode", 32'(asciicode), 32'(e.data));
            lastAddr = e.addr;
            lastData = e.data;
        end else begin
            checkOutput("waddr_hold", 32'(waddr), 32'(lastAddr));
            checkOutput("asciicode_hold", 32'(asciicode), 32'(lastData));
        end
        checkOutput("cursor_row", 32'(cursor_row), 32'(mRow));
        checkOutput("cursor_col", 32'(cursor_col), 32'(mCol));
        checkOutput("cursor_addr", 32'(cursor_addr), 32'(mRow * COLS + mCol));
        rdyExp   = e.rdy;
        addrSeen = e.en ? e.addr : 12'hFFF;
    endtask

    // Step until the model says the controller is ready again; junk is driven while busy
    task automatic runUntilIdle();
        logic        r;
        logic [11:0] a;
        r = 1'b0;
        for (int n = 0; n < CELLS + 10 && !r; n++) begin
            sampleCycle(r, a);
            if (!r) begin
                driveJunk();
            end
        end
        driveIdle();
    endtask

    // Present one input combination to an idle controller and record what it must do
    task automatic applyStimulus(input logic kv, input logic [7:0] code, input logic clr);
        key_valid    = kv;
        asciicode_in = code;
        clear_req    = clr;
        if (clr) begin
            pushGap();
            pushSweep(CELLS);
            mRow = 0;
            mCol = 0;
        end else if (kv) begin
            if (code >= 8'h20 && code <= 8'h7E) begin
                if (mRow == ROWS - 1 && mCol == COLS - 1) begin
                    pushWrite(CELLS - 1, code, 1'b0);
                    pushSweep(COLS);
                    mRow = 0;
                    mCol = 0;
                end else begin
                    pushWrite(mRow * COLS + mCol, code, 1'b1);
                    if (mCol < COLS - 1) begin
                        mCol++;
                    end else begin
                        mCol = 0;
                        mRow++;
                    end
                end
            end else if (code == 8'h08) begin
                if (mCol > 0) begin
                    mCol--;
                    pushWrite(mRow * COLS + mCol, 8'h20, 1'b1);
                end else if (mRow > 0) begin
                    mRow--;
                    mCol = COLS - 1;
                    pushWrite(mRow * COLS + mCol, 8'h20, 1'b1);
                end
            end else if (code == 8'h0D) begin
                if (mRow < ROWS - 1) begin
                    mRow++;
                    mCol = 0;
                end else begin
                    pushGap();
                    pushSweep(COLS);
                    mRow = 0;
                    mCol = 0;
                end
            end
        end
    endtask

    task automatic sendKey(input logic [7:0] code);
        applyStimulus(1'b1, code, 1'b0);
        runUntilIdle();
    endtask

    // Synchronous reset for one edge, check reset values, then follow the power-on clear
    task automatic doReset();
        reset = 1'b1;
        driveIdle();
        @(posedge clk50);
        #1;
        checkOutput("rst_en", 32'(en), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_waddr", 32'(waddr), 32'd0);
        checkOutput("rst_asciicode", 32'(asciicode), 32'd0);
        checkOutput("rst_cursor_addr", 32'(cursor_addr), 32'd0);
        checkOutput("rst_cursor_rowcol", {20'd0, cursor_row, cursor_col}, 32'd0);
        expQ.delete();
        mRow     = 0;
        mCol     = 0;
        lastAddr = '0;
        lastData = '0;
        reset    = 1'b0;
        pushSweep(CELLS);
        runUntilIdle();
    endtask

    task automatic moveTo(input int r, input int c);
        if (mRow == r && mCol > c) begin
            while (mCol > c) sendKey(8'h08);
        end else begin
            while (mRow != r) sendKey(8'h0D);
            while (mCol < c) sendKey(8'($urandom_range(32, 126)));
        end
    endtask

    initial begin
        logic        r;
        logic [11:0] a;
        logic        hit;
        int          pick;

        $display("[TB] start");
        doReset();

        sendKey(8'h41);
        sendKey(8'h42);

        moveTo(0, COLS - 1);
        sendKey(8'h5A);
        sendKey(8'h08);
        moveTo(0, 0);
        sendKey(8'h08);

        moveTo(ROWS - 1, COLS - 1);
        sendKey(8'h51);

        moveTo(ROWS - 1, 5);
        sendKey(8'h0D);
        moveTo(3, 7);
        sendKey(8'h0D);

        // Clear and key together: clear wins; then reset lands in the middle of the sweep
        applyStimulus(1'b1, 8'h41, 1'b1);
        hit = 1'b0;
        for (int n = 0; n < CELLS + 5 && !hit; n++) begin
            sampleCycle(r, a);
            driveJunk();
            if (a == 12'd500) hit = 1'b1;
        end
        checkOutput("reached_addr500", 32'(hit), 32'd1);
        doReset();

        for (int op = 0; op < 400; op++) begin
            pick = $urandom_range(0, 99);
            if (pick < 50) begin
                applyStimulus(1'b1, 8'($urandom_range(32, 126)), 1'b0);
            end else if (pick < 65) begin
                applyStimulus(1'b1, 8'h08, 1'b0);
            end else if (pick < 80) begin
                applyStimulus(1'b1, 8'h0D, 1'b0);
            end else if (pick < 90) begin
                applyStimulus(1'b1, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(127, 255)) : 8'h1B, 1'b0);
            end else if (pick < 99) begin
                applyStimulus(1'b0, 8'($urandom), 1'b0);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(32, 126)), 1'b1);
            end
            runUntilIdle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
